// File: rtl/deadlock_watchdog.sv
// Deadlock watchdog for a dataflow region: declares deadlock when every process is
// idle or blocked (with at least one real block) for thr_q consecutive cycles.
module deadlock_watchdog #(
    parameter int N_AXIS = 12,
    parameter int N_INST = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    input  logic              enable,
    input  logic [15:0]       threshold,
    input  logic              clear,
    output logic              deadlock,
    output logic              deadlock_irq,
    output logic [N_AXIS-1:0] snap_axis,
    output logic [N_INST-1:0] snap_inst_block,
    output logic [31:0]       stall_cycles,
    output logic [7:0]        event_count,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WATCH    = 2'd1,
        ST_SUSPECT  = 2'd2,
        ST_DEADLOCK = 2'd3
    } state_t;

    state_t      fsm_q;
    logic [15:0] thr_q;
    logic        stall_cond;
    logic [15:0] thr_load;
    logic [31:0] stall_next;
    logic        hit_threshold;

    // All-idle with no blocked process or stream is a quiet region, not a stall.
    assign stall_cond    = (&(inst_idle_sigs | inst_block_sigs)) &&
                           ((|inst_block_sigs) || (|axis_block_sigs));
    assign thr_load      = (threshold < 16'd2) ? 16'd2 : threshold;
    assign stall_next    = (stall_cycles == 32'hFFFF_FFFF) ? stall_cycles : stall_cycles + 32'd1;
    assign hit_threshold = (stall_next == {16'd0, thr_q});
    assign state         = fsm_q;

    // clear is sampled on every edge and treated as a one-cycle acknowledge pulse;
    // it only acts in SUSPECT and DEADLOCK.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            fsm_q           <= ST_IDLE;
            thr_q           <= 16'd2;
            deadlock        <= 1'b0;
            deadlock_irq    <= 1'b0;
            snap_axis       <= '0;
            snap_inst_block <= '0;
            stall_cycles    <= 32'd0;
            event_count     <= 8'd0;
        end else begin
            deadlock_irq <= 1'b0;
            case (fsm_q)
                ST_IDLE: begin
                    if (enable) begin
                        fsm_q <= ST_WATCH;
                        thr_q <= thr_load;
                    end
                end
                ST_WATCH: begin
                    if (!enable) begin
                        fsm_q        <= ST_IDLE;
                        stall_cycles <= 32'd0;
                    end else if (stall_cond) begin
                        fsm_q        <= ST_SUSPECT;
                        stall_cycles <= 32'd1;
                    end else begin
                        stall_cycles <= 32'd0;
                    end
                end
                ST_SUSPECT: begin
                    if (!enable) begin
                        fsm_q        <= ST_IDLE;
                        stall_cycles <= 32'd0;
                    end else if (clear || !stall_cond) begin
                        fsm_q        <= ST_WATCH;
                        stall_cycles <= 32'd0;
                    end else begin
                        stall_cycles <= stall_next;
                        if (hit_threshold) begin
                            fsm_q           <= ST_DEADLOCK;
                            deadlock        <= 1'b1;
                            deadlock_irq    <= 1'b1;
                            snap_axis       <= axis_block_sigs;
                            snap_inst_block <= inst_block_sigs;
                            if (event_count != 8'hFF) begin
                                event_count <= event_count + 8'd1;
                            end
                        end
                    end
                end
                ST_DEADLOCK: begin
                    if (clear) begin
                        fsm_q           <= enable ? ST_WATCH : ST_IDLE;
                        deadlock        <= 1'b0;
                        snap_axis       <= '0;
                        snap_inst_block <= '0;
                        stall_cycles    <= 32'd0;
                    end else if (stall_cond) begin
                        stall_cycles <= stall_next;
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/deadlock_watchdog.md
DEADLOCK_WATCHDOG -- requirements
Module: deadlock_watchdog

Interface
REQ-001 Parameter N_AXIS, default 12, number of AXI-stream blocking indicators.
REQ-002 Parameter N_INST, default 16, number of dataflow-process idle/block indicator pairs.
REQ-003 ap_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 ap_rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 axis_block_sigs  input  N_AXIS  1 = stream port stalled on TDATA handshake.
REQ-006 inst_idle_sigs  input  N_INST  1 = process idle.
REQ-007 inst_block_sigs  input  N_INST  1 = process blocked on a FIFO or on ap_continue.
REQ-008 enable  input  1  arms the watchdog.
REQ-009 threshold  input  16  consecutive stall cycles required to declare deadlock.
REQ-010 clear  input  1  single-cycle pulse; acknowledges and clears a deadlock.
REQ-011 deadlock  output  1  sticky deadlock flag.
REQ-012 deadlock_irq  output  1  one-cycle pulse on entry to DEADLOCK.
REQ-013 snap_axis  output  N_AXIS  axis_block_sigs captured at detection.
REQ-014 snap_inst_block  output  N_INST  inst_block_sigs captured at detection.
REQ-015 stall_cycles  output  32  current consecutive stall-run length, saturating.
REQ-016 event_count  output  8  deadlocks detected since reset, saturating at 255.
REQ-017 state  output  2  FSM state: 0 IDLE, 1 WATCH, 2 SUSPECT, 3 DEADLOCK.

Function
REQ-018 stall_cond SHALL be 1 iff every bit of (inst_idle_sigs | inst_block_sigs) is 1 AND at least one bit of inst_block_sigs or axis_block_sigs is 1; all-idle alone SHALL NOT count as a stall.
REQ-019 thr_q SHALL load max(threshold, 2) on the IDLE->WATCH transition; threshold changes at other times SHALL be ignored.
REQ-020 IDLE: enable=1 -> WATCH next cycle; otherwise remain.
REQ-021 WATCH: enable=0 -> IDLE; else stall_cond=1 -> SUSPECT with stall_cycles<=1; else remain with stall_cycles=0.
REQ-022 SUSPECT: enable=0 -> IDLE with stall_cycles<=0; stall_cond=0 -> WATCH with stall_cycles<=0; stall_cond=1 -> stall_cycles+1; if stall_cycles+1 == thr_q -> DEADLOCK.
REQ-023 DEADLOCK entry cycle SHALL register snap_axis/snap_inst_block from the inputs present in the threshold-reaching cycle, set deadlock=1, pulse deadlock_irq for exactly one cycle, and increment event_count (saturating at 255).
REQ-024 DEADLOCK SHALL be sticky: remain regardless of stall_cond or enable until clear=1; stall_cycles SHALL keep incrementing while stall_cond=1, hold otherwise, and saturate at 0xFFFFFFFF.
REQ-025 clear in DEADLOCK -> WATCH if enable=1, else IDLE; deadlock, snap_axis, snap_inst_block and stall_cycles SHALL go to 0 on the next edge; event_count SHALL be retained.
REQ-026 clear in SUSPECT SHALL take priority over the transition to DEADLOCK: -> WATCH with stall_cycles<=0, no irq, and no snapshot.
REQ-027 clear in IDLE or WATCH SHALL have no effect.
REQ-028 All outputs SHALL be registered; the detection latency is thr_q cycles from the first stall cycle to deadlock=1.

Reset
REQ-029 ap_rst_n=0 SHALL immediately force state=IDLE, deadlock=0, deadlock_irq=0, snap_axis=0, snap_inst_block=0, stall_cycles=0, event_count=0, and thr_q=2.
REQ-030 Reset asserted mid-run (any state) SHALL abort the run; no irq SHALL be generated on reset release.

Verification
REQ-031 enable=1, threshold=4, all inst blocked for 4 cycles -> deadlock=1 on the 4th edge after the first stall, one irq pulse, event_count=1.
REQ-032 threshold=4, 3 stall cycles then one non-stall cycle, repeated -> deadlock stays 0 and stall_cycles returns to 0 after each break.
REQ-033 threshold=0 -> treated as 2; deadlock=1 after 2 stall cycles; snap_axis equals the axis_block_sigs value (e.g. 0x100) present on the 2nd stall cycle.
REQ-034 In DEADLOCK, drop stall_cond and enable -> deadlock stays 1; clear pulse -> IDLE, snap=0, stall_cycles=0, event_count retained.
REQ-035 clear asserted in the same cycle the threshold is reached -> no deadlock, no irq, state=WATCH.
REQ-036 Reset pulse while in SUSPECT with stall_cycles=3 -> all outputs 0 immediately, state=IDLE, and no irq after release.
